en_range_scan: RTL and testbench

EN_RANGE_SCAN -- requirements
Module: en_range_scan

---
 rtl/en_range_pkg.sv | 21 ++
 rtl/en_range_scan_if.sv | 45 ++++
 rtl/en_range_match.sv | 19 +
 rtl/en_range_scan.sv | 162 ++++++++++++++++
 tb/tb_en_range_scan.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/en_range_pkg.sv
// Shared types and default sizing for the element-table range scanner.
package en_range_pkg;

   localparam int unsigned W_DEF         = 8;
   localparam int unsigned DEPTH_DEF     = 16;
   localparam int unsigned SCOPE_MAX_DEF = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // One element-table record at the default metadata width.
   typedef struct packed {
      logic             eltDef;
      logic             isMetadata;
      logic [W_DEF-1:0] metadata;
   } entry_t;

endpackage

// File: rtl/en_range_scan_if.sv
// Table-write, lookup-request and response signals of the range scanner.
interface en_range_scan_if #(
   parameter int unsigned W     = en_range_pkg::W_DEF,
   parameter int unsigned DEPTH = en_range_pkg::DEPTH_DEF
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic          wr_en;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic          wr_eltDef;
   logic          wr_isMetadata;
   logic [W-1:0]  wr_metadata;

   logic          req_valid;
   logic          req_ready;
   logic [W-1:0]  req_handle;
   logic [W-1:0]  req_low;
   logic [W-1:0]  req_high;
   logic          req_mode;

   logic          resp_valid;
   logic          resp_ready;
   logic          resp_hit;
   logic [AW-1:0] resp_index;
   logic [AW:0]   resp_count;
   logic [W-1:0]  resp_value;

   modport master (
      output wr_en, wr_addr, wr_eltDef, wr_isMetadata, wr_metadata,
      output req_valid, req_handle, req_low, req_high, req_mode,
      output resp_ready,
      input  wr_ready, req_ready,
      input  resp_valid, resp_hit, resp_index, resp_count, resp_value
   );

   modport slave (
      input  wr_en, wr_addr, wr_eltDef, wr_isMetadata, wr_metadata,
      input  req_valid, req_handle, req_low, req_high, req_mode,
      input  resp_ready,
      output wr_ready, req_ready,
      output resp_valid, resp_hit, resp_index, resp_count, resp_value
   );

endinterface

// File: rtl/en_range_match.sv
// Combinational match test of one table entry against a lookup handle.
module en_range_match import en_range_pkg::*; #(
   parameter int unsigned W         = W_DEF,
   parameter int unsigned SCOPE_MAX = SCOPE_MAX_DEF
) (
   input  logic         elt_def,
   input  logic         is_metadata,
   input  logic [W-1:0] metadata,
   input  logic [W-1:0] handle,
   output logic         match_c
);

   // Entry must be a defined, in-scope metadata record equal to the handle.
   assign match_c = is_metadata
                 && (32'(metadata) <= SCOPE_MAX)
                 && elt_def
                 && (metadata == handle);

endmodule

// File: rtl/en_range_scan.sv
// Flop-based element table with a sequential one-entry-per-clock lookup scan.
module en_range_scan import en_range_pkg::*; #(
   parameter int unsigned W         = W_DEF,
   parameter int unsigned DEPTH     = DEPTH_DEF,
   parameter int unsigned SCOPE_MAX = SCOPE_MAX_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   en_range_scan_if.slave  bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   state_t        state;
   logic [AW-1:0] idx;
   logic [AW-1:0] first_idx;
   logic [CW-1:0] cnt;
   logic          seen;
   logic [W-1:0]  cap_handle;
   logic [W-1:0]  cap_low;
   logic [W-1:0]  cap_high;
   logic          cap_mode;

   logic          req_ready_q;
   logic          wr_ready_q;
   logic          resp_valid_q;
   logic          resp_hit_q;
   logic [AW-1:0] resp_index_q;
   logic [CW-1:0] resp_count_q;
   logic [W-1:0]  resp_value_q;

   logic          tbl_elt_def [DEPTH];
   logic          tbl_is_md   [DEPTH];
   logic [W-1:0]  tbl_md      [DEPTH];

   logic          match_c;
   logic          last_c;
   logic          any_c;
   logic          wr_fire_c;
   logic [CW-1:0] cnt_next_c;
   logic [AW-1:0] low_idx_c;

   en_range_match #(
      .W         (W),
      .SCOPE_MAX (SCOPE_MAX)
   ) u_match (
      .elt_def     (tbl_elt_def[idx]),
      .is_metadata (tbl_is_md[idx]),
      .metadata    (tbl_md[idx]),
      .handle      (cap_handle),
      .match_c     (match_c)
   );

   assign wr_fire_c  = bus.wr_en && wr_ready_q;
   assign last_c     = (idx == AW'(DEPTH - 1));
   assign cnt_next_c = cnt + CW'(match_c);
   assign any_c      = seen || match_c;
   assign low_idx_c  = seen ? first_idx : (match_c ? idx : '0);

   // Table storage; wr_ready is low throughout SCAN so a scan sees a frozen table.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tbl_elt_def[i] <= 1'b0;
            tbl_is_md[i]   <= 1'b0;
            tbl_md[i]      <= '0;
         end
      end else if (wr_fire_c) begin
         tbl_elt_def[bus.wr_addr] <= bus.wr_eltDef;
         tbl_is_md[bus.wr_addr]   <= bus.wr_isMetadata;
         tbl_md[bus.wr_addr]      <= bus.wr_metadata;
      end
   end

   // Request capture, scan sequencing and registered response/ready outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         first_idx    <= '0;
         cnt          <= '0;
         seen         <= 1'b0;
         cap_handle   <= '0;
         cap_low      <= '0;
         cap_high     <= '0;
         cap_mode     <= 1'b0;
         req_ready_q  <= 1'b0;
         wr_ready_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_index_q <= '0;
         resp_count_q <= '0;
         resp_value_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               req_ready_q <= 1'b1;
               wr_ready_q  <= 1'b1;
               if (bus.req_valid && req_ready_q) begin
                  cap_handle  <= bus.req_handle;
                  cap_low     <= bus.req_low;
                  cap_high    <= bus.req_high;
                  cap_mode    <= bus.req_mode;
                  idx         <= '0;
                  first_idx   <= '0;
                  cnt         <= '0;
                  seen        <= 1'b0;
                  req_ready_q <= 1'b0;
                  wr_ready_q  <= 1'b0;
                  state       <= SCAN;
               end
            end
            SCAN: begin
               cnt <= cnt_next_c;
               if (match_c && !seen) begin
                  seen      <= 1'b1;
                  first_idx <= idx;
               end
               if (!cap_mode && match_c) begin
                  resp_valid_q <= 1'b1;
                  resp_hit_q   <= 1'b1;
                  resp_index_q <= idx;
                  resp_count_q <= CW'(1);
                  resp_value_q <= cap_high;
                  wr_ready_q   <= 1'b1;
                  state        <= DONE;
               end else if (last_c) begin
                  resp_valid_q <= 1'b1;
                  resp_hit_q   <= any_c;
                  resp_index_q <= low_idx_c;
                  resp_count_q <= cnt_next_c;
                  resp_value_q <= any_c ? cap_high : cap_low;
                  wr_ready_q   <= 1'b1;
                  state        <= DONE;
               end else begin
                  idx <= idx + AW'(1);
               end
            end
            DONE: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.wr_ready   = wr_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_hit   = resp_hit_q;
   assign bus.resp_index = resp_index_q;
   assign bus.resp_count = resp_count_q;
   assign bus.resp_value = resp_value_q;

endmodule

// File: tb/tb_en_range_scan.sv
// Bench for en_range_scan: directed cases plus randomized traffic against a lookup model.
module tb_en_range_scan;
   import en_range_pkg::*;

   localparam int unsigned W     = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned SCOPE = 7;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   en_range_scan_if #(.W(W), .DEPTH(DEPTH)) bus ();

   en_range_scan #(.W(W), .DEPTH(DEPTH), .SCOPE_MAX(SCOPE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   entry_t     m_tbl [DEPTH];
   bit         m_req_ready, m_wr_ready, m_resp_valid;
   int         m_left;
   bit         e_hit;
   bit [3:0]   e_idx;
   bit [4:0]   e_cnt;
   bit [7:0]   e_val;

   function automatic bit is_match(input entry_t e, input logic [7:0] h);
      return e.eltDef && e.isMetadata && (e.metadata <= 8'(SCOPE)) && (e.metadata == h);
   endfunction

   // Whole lookup is resolved at acceptance; only the response delay is counted down.
   always @(posedge clk or negedge rst_n) begin : model
      bit acc, wf, rel;
      int first, n;
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) m_tbl[i] = '0;
         m_req_ready = 0; m_wr_ready = 0; m_resp_valid = 0; m_left = 0;
         e_hit = 0; e_idx = 0; e_cnt = 0; e_val = 0;
      end else begin
         acc = m_req_ready && bus.req_valid;
         wf  = m_wr_ready && bus.wr_en;
         rel = m_resp_valid && bus.resp_ready;
         if (wf) m_tbl[bus.wr_addr] = '{bus.wr_eltDef, bus.wr_isMetadata, bus.wr_metadata};
         if (acc) begin
            first = -1; n = 0;
            for (int i = 0; i < int'(DEPTH); i++)
               if (is_match(m_tbl[i], bus.req_handle)) begin
                  n++;
                  if (first < 0) first = i;
               end
            if (!bus.req_mode && first >= 0) begin
               m_left = first + 1; e_hit = 1; e_idx = 4'(first); e_cnt = 5'd1;
            end else begin
               m_left = DEPTH; e_hit = (n > 0);
               e_idx = (first >= 0) ? 4'(first) : 4'd0;
               e_cnt = 5'(n);
            end
            e_val = e_hit ? bus.req_high : bus.req_low;
            m_req_ready = 0; m_wr_ready = 0;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_resp_valid = 1; m_wr_ready = 1; end
         end else if (rel) begin
            m_resp_valid = 0; m_req_ready = 1;
         end else if (!m_resp_valid) begin
            m_req_ready = 1; m_wr_ready = 1;
         end
      end
   end

   // Per-cycle comparison of DUT outputs with the model.
   always @(negedge clk) begin
      chk("req_ready",  32'(bus.req_ready),  32'(m_req_ready));
      chk("wr_ready",   32'(bus.wr_ready),   32'(m_wr_ready));
      chk("resp_valid", 32'(bus.resp_valid), 32'(m_resp_valid));
      if (m_resp_valid || !rst_n) begin
         chk("resp_hit",   32'(bus.resp_hit),   32'(e_hit));
         chk("resp_index", 32'(bus.resp_index), 32'(e_idx));
         chk("resp_count", 32'(bus.resp_count), 32'(e_cnt));
         chk("resp_value", 32'(bus.resp_value), 32'(e_val));
      end
   end

   // ---------------- drivers ----------------
   task automatic do_write(input logic [3:0] a, input entry_t e);
      int t;
      bus.wr_addr = a; bus.wr_eltDef = e.eltDef;
      bus.wr_isMetadata = e.isMetadata; bus.wr_metadata = e.metadata;
      bus.wr_en = 1'b1;
      t = 0;
      while (!bus.wr_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("wr_timeout", 32'd1, 32'd0);
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic do_req(input logic [7:0] h, input logic [7:0] lo, input logic [7:0] hi,
                         input bit mode, input int hold, input bit scan_wr,
                         input bit same_wr, input logic [3:0] sa, input entry_t se,
                         output int lat, output bit hit, output logic [3:0] idx,
                         output logic [4:0] cnt, output logic [7:0] val);
      int t;
      bus.req_handle = h; bus.req_low = lo; bus.req_high = hi; bus.req_mode = mode;
      bus.req_valid = 1'b1;
      if (same_wr) begin
         bus.wr_addr = sa; bus.wr_eltDef = se.eltDef;
         bus.wr_isMetadata = se.isMetadata; bus.wr_metadata = se.metadata;
         bus.wr_en = 1'b1;
      end
      t = 0;
      while (!bus.req_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("req_timeout", 32'd1, 32'd0);
      @(negedge clk);
      bus.req_valid = 1'b0; bus.wr_en = 1'b0;
      bus.req_handle = 8'($urandom); bus.req_low = 8'($urandom);
      bus.req_high = 8'($urandom); bus.req_mode = 1'($urandom);
      if (scan_wr) begin
         bus.wr_addr = 4'd3; bus.wr_eltDef = 1'b1; bus.wr_isMetadata = 1'b1;
         bus.wr_metadata = h; bus.wr_en = 1'b1;
      end
      lat = 0;
      while (!bus.resp_valid && lat < 64) begin
         @(negedge clk);
         lat++;
         if (scan_wr && !bus.resp_valid) chk("scan_wr_ready", 32'(bus.wr_ready), 32'd0);
      end
      if (lat >= 64) chk("resp_timeout", 32'd1, 32'd0);
      bus.wr_en = 1'b0;
      hit = bus.resp_hit; idx = bus.resp_index; cnt = bus.resp_count; val = bus.resp_value;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
         chk("hold_value", 32'(bus.resp_value), 32'(val));
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
   endtask

   function automatic entry_t mk(input bit d, input bit m, input logic [7:0] md);
      entry_t e;
      e.eltDef = d; e.isMetadata = m; e.metadata = md;
      return e;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int       lat;
      bit       hit;
      logic [3:0] idx;
      logic [4:0] cnt;
      logic [7:0] val;
      entry_t   z;
      z = '0;
      bus.wr_en = 0; bus.wr_addr = 0; bus.wr_eltDef = 0; bus.wr_isMetadata = 0; bus.wr_metadata = 0;
      bus.req_valid = 0; bus.req_handle = 0; bus.req_low = 0; bus.req_high = 0; bus.req_mode = 0;
      bus.resp_ready = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_wr_ready",  32'(bus.wr_ready),  32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("post_rst_wr_ready",  32'(bus.wr_ready),  32'd1);

      // first-match lookup
      do_write(4'd3, mk(1, 1, 8'd5));
      do_req(8'd5, 8'h11, 8'hAA, 0, 0, 0, 0, 4'd0, z, lat, hit, idx, cnt, val);
      chk("t1_lat", 32'(lat), 32'd4);   chk("t1_hit", 32'(hit), 32'd1);
      chk("t1_idx", 32'(idx), 32'd3);   chk("t1_cnt", 32'(cnt), 32'd1);
      chk("t1_val", 32'(val), 32'hAA);

      // count-all lookup
      do_write(4'd2,  mk(1, 1, 8'd6));
      do_write(4'd9,  mk(1, 1, 8'd6));
      do_write(4'd15, mk(1, 1, 8'd6));
      do_req(8'd6, 8'h11, 8'hAA, 1, 0, 0, 0, 4'd0, z, lat, hit, idx, cnt, val);
      chk("t2_lat", 32'(lat), 32'd16);  chk("t2_hit", 32'(hit), 32'd1);
      chk("t2_idx", 32'(idx), 32'd2);   chk("t2_cnt", 32'(cnt), 32'd3);
      chk("t2_val", 32'(val), 32'hAA);

      // out-of-scope metadata and non-metadata entry both miss
      do_write(4'd0, mk(1, 1, 8'd9));
      do_req(8'd9, 8'h11, 8'hAA, 0, 0, 0, 0, 4'd0, z, lat, hit, idx, cnt, val);
      chk("t3a_lat", 32'(lat), 32'd16); chk("t3a_hit", 32'(hit), 32'd0);
      chk("t3a_cnt", 32'(cnt), 32'd0);  chk("t3a_val", 32'(val), 32'h11);
      chk("t3a_idx", 32'(idx), 32'd0);
      do_write(4'd1, mk(1, 0, 8'd4));
      do_req(8'd4, 8'h11, 8'hAA, 1, 0, 0, 0, 4'd0, z, lat, hit, idx, cnt, val);
      chk("t3b_hit", 32'(hit), 32'd0);  chk("t3b_cnt", 32'(cnt), 32'd0);
      chk("t3b_val", 32'(val), 32'h11);

      // response held for 5 cycles, then released
      do_req(8'd5, 8'h11, 8'hAA, 0, 5, 0, 0, 4'd0, z, lat, hit, idx, cnt, val);
      chk("t4_rel_valid", 32'(bus.resp_valid), 32'd0);
      chk("t4_rel_ready", 32'(bus.req_ready),  32'd1);

      // write attempted during scan must not land
      do_req(8'd6, 8'h11, 8'hAA, 1, 0, 1, 0, 4'd0, z, lat, hit, idx, cnt, val);
      chk("t5_cnt", 32'(cnt), 32'd3);   chk("t5_idx", 32'(idx), 32'd2);

      // write in the acceptance cycle is visible to that scan
      do_req(8'd7, 8'h11, 8'hAA, 0, 0, 0, 1, 4'd4, mk(1, 1, 8'd7), lat, hit, idx, cnt, val);
      chk("t6_lat", 32'(lat), 32'd5);   chk("t6_hit", 32'(hit), 32'd1);
      chk("t6_idx", 32'(idx), 32'd4);

      // reset in the middle of a scan
      bus.req_handle = 8'd5; bus.req_low = 8'h11; bus.req_high = 8'hAA; bus.req_mode = 1'b1;
      bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
      chk("mid_rst_hit",   32'(bus.resp_hit),   32'd0);
      chk("mid_rst_index", 32'(bus.resp_index), 32'd0);
      chk("mid_rst_count", 32'(bus.resp_count), 32'd0);
      chk("mid_rst_value", 32'(bus.resp_value), 32'd0);
      chk("mid_rst_rrdy",  32'(bus.req_ready),  32'd0);
      chk("mid_rst_wrdy",  32'(bus.wr_ready),   32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (DEPTH + 4) begin
         @(negedge clk);
         chk("no_resp_after_rst", 32'(bus.resp_valid), 32'd0);
      end
      do_req(8'd5, 8'h11, 8'hAA, 0, 0, 0, 0, 4'd0, z, lat, hit, idx, cnt, val);
      chk("t7_hit", 32'(hit), 32'd0);   chk("t7_val", 32'(val), 32'h11);

      // randomized traffic
      for (int it = 0; it < 120; it++) begin
         int nw;
         nw = $urandom_range(0, 3);
         for (int k = 0; k < nw; k++)
            do_write(4'($urandom), mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                                      8'($urandom_range(0, 10))));
         do_req(8'($urandom_range(0, 10)), 8'($urandom), 8'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                4'($urandom), mk(1, 1, 8'($urandom_range(0, 10))), lat, hit, idx, cnt, val);
      end

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
